// File: rtl/counter_rr_sched_if.sv
// Request/grant bundle between the requesting units and the shared-counter scheduler.
// The scheduler side uses the slave modport and requesters use master.
interface counter_rr_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 3,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] len;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic [ID_W-1:0]          cur_id;
  logic [CNT_W-1:0]         count;
  logic [NUM_REQ-1:0]       done;

  modport master (
    output req, len,
    input  grant, busy, cur_id, count, done
  );

  modport slave (
    input  req, len,
    output grant, busy, cur_id, count, done
  );
endinterface

// File: rtl/counter_rr_sched.sv
// Round-robin scheduler that lends one shared up-counter to NUM_REQ requesters,
// running clear/count/terminate for the winner and pulsing done on completion.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no run active; arbitrate among pending requests from ptr
// S_RUN  | grant held for cur_id, count increments up to len_q
// S_DONE | one-cycle done pulse to cur_id, counter holds final value
module counter_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 3,
  parameter int ID_W    = 2
) (
  input  logic              clock,
  input  logic              reset,
  counter_rr_sched_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_q, grant_nxt;
  logic [NUM_REQ-1:0] done_q, done_nxt;
  logic               busy_q, busy_nxt;
  logic [ID_W-1:0]    cur_id_q, cur_id_nxt;
  logic [ID_W-1:0]    ptr_q, ptr_nxt;
  logic [CNT_W-1:0]   count_q, count_nxt;
  logic [CNT_W-1:0]   len_q, len_nxt;

  logic               found;
  logic [ID_W-1:0]    win;

  // First set request at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      cur_id_q <= '0;
      ptr_q    <= '0;
      count_q  <= '0;
      len_q    <= '0;
    end else begin
      state    <= state_nxt;
      grant_q  <= grant_nxt;
      done_q   <= done_nxt;
      busy_q   <= busy_nxt;
      cur_id_q <= cur_id_nxt;
      ptr_q    <= ptr_nxt;
      count_q  <= count_nxt;
      len_q    <= len_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_q;
    done_nxt   = '0;
    busy_nxt   = busy_q;
    cur_id_nxt = cur_id_q;
    ptr_nxt    = ptr_q;
    count_nxt  = count_q;
    len_nxt    = len_q;

    case (state)
      S_IDLE: begin
        count_nxt = '0;
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        if (found) begin
          state_nxt       = S_RUN;
          grant_nxt       = '0;
          grant_nxt[win]  = 1'b1;
          cur_id_nxt      = win;
          len_nxt         = bus.len[win*CNT_W +: CNT_W];
          busy_nxt        = 1'b1;
          ptr_nxt         = (int'(win) == NUM_REQ - 1) ? '0 : win + ID_W'(1);
        end
      end
      S_RUN: begin
        // Abort wins over completion when both happen in the same cycle.
        if (!bus.req[cur_id_q]) begin
          state_nxt = S_IDLE;
          grant_nxt = '0;
          busy_nxt  = 1'b0;
          count_nxt = '0;
        end else if (count_q == len_q) begin
          state_nxt          = S_DONE;
          grant_nxt          = '0;
          done_nxt[cur_id_q] = 1'b1;
        end else begin
          count_nxt = count_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
        count_nxt = '0;
      end
      default: begin
        state_nxt = S_IDLE;
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        count_nxt = '0;
      end
    endcase
  end

  assign bus.grant  = grant_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign bus.cur_id = cur_id_q;
  assign bus.count  = count_q;

endmodule

// File: tb/tb_counter_rr_sched.sv
// Directed bench for counter_rr_sched: reset, single run, fairness, length
// boundaries, abort and reset in the middle of a run.
module tb_counter_rr_sched;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 3;
  localparam int ID_W    = 2;

  logic clock;
  logic reset;

  counter_rr_sched_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .ID_W(ID_W)) bus ();

  counter_rr_sched #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".grant"}, 32'(bus.grant), 32'h0);
    chk({tag, ".done"},  32'(bus.done),  32'h0);
    chk({tag, ".busy"},  32'(bus.busy),  32'h0);
    chk({tag, ".count"}, 32'(bus.count), 32'h0);
  endtask

  task automatic chk_run(input string tag, input int w, input int c);
    chk({tag, ".grant"},  32'(bus.grant),  32'(1 << w));
    chk({tag, ".cur_id"}, 32'(bus.cur_id), 32'(w));
    chk({tag, ".count"},  32'(bus.count),  32'(c));
    chk({tag, ".busy"},   32'(bus.busy),   32'h1);
    chk({tag, ".done"},   32'(bus.done),   32'h0);
  endtask

  task automatic chk_done(input string tag, input int w, input int c);
    chk({tag, ".done"},  32'(bus.done),  32'(1 << w));
    chk({tag, ".grant"}, 32'(bus.grant), 32'h0);
    chk({tag, ".busy"},  32'(bus.busy),  32'h1);
    chk({tag, ".count"}, 32'(bus.count), 32'(c));
  endtask

  int order [6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    reset   = 1'b0;
    bus.req = '0;
    bus.len = '0;
    #1 reset = 1'b1;
    #1;
    chk_idle("rst0");
    chk("rst0.cur_id", 32'(bus.cur_id), 32'h0);
    step();
    step();
    reset = 1'b0;

    // req low for 10 cycles: nothing happens
    for (int i = 0; i < 10; i++) begin
      step();
      chk_idle("idle10");
    end

    // single run, requester 1, len 5; a late len change must be ignored
    bus.req = 4'b0010;
    bus.len = 12'(5 << 3);
    for (int i = 0; i <= 5; i++) begin
      step();
      chk_run("run1", 1, i);
      if (i == 2) bus.len = '0;
    end
    step();
    chk_done("run1.end", 1, 5);
    bus.req = '0;
    step();
    chk_idle("run1.after");

    // fairness from a fresh reset (ptr = 0)
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    chk("fair.rst.cur_id", 32'(bus.cur_id), 32'h0);
    bus.req = 4'b1011;
    bus.len = 12'b001_001_001_001;
    for (int r = 0; r < 6; r++) begin
      step();
      chk_run("fair.c0", order[r], 0);
      step();
      chk_run("fair.c1", order[r], 1);
      step();
      chk_done("fair.done", order[r], 1);
      step();
      if (r == 5) bus.req = '0;
      chk_idle("fair.bubble");
    end
    step();
    chk_idle("fair.quiet");

    // len = 0 on requester 0 (ptr back at 0)
    bus.req = 4'b0001;
    bus.len = '0;
    step();
    chk_run("len0", 0, 0);
    step();
    chk_done("len0.end", 0, 0);
    bus.req = '0;
    step();
    chk_idle("len0.after");

    // len = max on requester 2: no wrap
    bus.req = 4'b0100;
    bus.len = 12'(7 << 6);
    for (int i = 0; i <= 7; i++) begin
      step();
      chk_run("lenmax", 2, i);
    end
    step();
    chk_done("lenmax.end", 2, 7);
    bus.req = '0;
    step();
    chk_idle("lenmax.after");

    // abort: requester 2 drops at count 3, pending requester 0 follows
    bus.req = 4'b0100;
    bus.len = 12'((6 << 6) | 2);
    step();
    chk_run("abort.c0", 2, 0);
    bus.req = 4'b0101;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk_run("abort.cnt", 2, i);
    end
    bus.req = 4'b0001;
    step();
    chk_idle("abort.drop");
    step();
    chk_run("abort.next", 0, 0);
    bus.req = '0;
    step();
    chk_idle("abort.next.drop");

    // reset while count = 4, then ptr restarts at 0
    bus.req = 4'b0100;
    bus.len = 12'(7 << 6);
    step();
    chk_run("rstrun.c0", 2, 0);
    for (int i = 1; i <= 4; i++) step();
    chk_run("rstrun.c4", 2, 4);
    #2 reset = 1'b1;
    #1;
    chk_idle("rstrun.async");
    chk("rstrun.cur_id", 32'(bus.cur_id), 32'h0);
    reset   = 1'b0;
    bus.req = 4'b0110;
    bus.len = 12'(2 << 3);
    step();
    chk_run("rstrun.win1", 1, 0);
    bus.req = '0;
    step();
    chk_idle("rstrun.end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
